maj_bist_checker: RTL and testbench



---
 rtl/maj_pkg.sv | 20 ++
 rtl/maj_vec_gen.sv | 45 ++++
 rtl/maj_bist_checker.sv | 181 ++++++++++++++++++
 tb/tb_maj_bist_checker.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/maj_pkg.sv
// Shared definitions for the majority-netlist BIST harness: LFSR taps, FSM states
// and the majority threshold helper.
package maj_pkg;

    // Galois taps for x^64 + x^63 + x^61 + x^60 + 1, right-shifting form.
    localparam logic [63:0] MAJ_LFSR_POLY = 64'hD800_0000_0000_0000;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_COUNT   = 3'd2,
        ST_COMPARE = 3'd3,
        ST_DONE    = 3'd4
    } maj_bist_state_t;

    function automatic int maj_thresh(input int n);
        return (n + 1) / 2;
    endfunction

endpackage

// File: rtl/maj_vec_gen.sv
// Test-vector generator: 64-bit incrementing counter or right-shifting Galois LFSR.
// Latency: state updates on the edge where load or adv is high; load has priority.
module maj_vec_gen
    import maj_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        adv,
    input  logic        mode,
    input  logic [63:0] seed,
    output logic [63:0] state_o
);

    logic [63:0] state_q, state_d;
    logic        mode_q, mode_d;
    logic [63:0] lfsr_next;

    assign lfsr_next = (state_q >> 1) ^ (state_q[0] ? MAJ_LFSR_POLY : 64'd0);

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        if (load) begin
            mode_d = mode;
            // An all-zero LFSR would lock up, so a zero seed starts from 1 instead.
            state_d = (mode && (seed == 64'd0)) ? 64'd1 : seed;
        end else if (adv) begin
            state_d = mode_q ? lfsr_next : state_q + 64'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= 64'd0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/maj_bist_checker.sv
// BIST harness for an N-input majority netlist: drives x_o, popcounts the vector
// bit-serially over N cycles and checks y0_i; N+2 cycles per vector.
module maj_bist_checker
    import maj_pkg::*;
#(
    parameter int N      = 51,
    parameter int THRESH = maj_thresh(N),
    parameter int CNT_W  = 32,
    parameter int ERR_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [63:0]      seed,
    input  logic [CNT_W-1:0] num_vec,
    input  logic             y0_i,
    output logic [N-1:0]     x_o,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic             fail_valid,
    output logic [N-1:0]     fail_vec,
    output logic [CNT_W-1:0] fail_idx,
    output logic [CNT_W-1:0] vec_idx
);

    localparam int PC_W = $clog2(N + 1);
    localparam logic [PC_W-1:0] THRESH_V = PC_W'(THRESH);
    localparam logic [PC_W-1:0] N_V      = PC_W'(N);

    maj_bist_state_t  state_q, state_d;
    logic [CNT_W-1:0] num_vec_q, num_vec_d;
    logic [N-1:0]     x_q, x_d;
    logic [N-1:0]     sh_q, sh_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [PC_W-1:0]  cnt_q, cnt_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             fail_valid_q, fail_valid_d;
    logic [N-1:0]     fail_vec_q, fail_vec_d;
    logic [CNT_W-1:0] fail_idx_q, fail_idx_d;
    logic [CNT_W-1:0] vec_idx_q, vec_idx_d;
    logic             pass_q, pass_d;
    logic             done_q, done_d;

    logic             gen_load, gen_adv;
    logic [63:0]      gen_state;
    logic             ref_bit;

    maj_vec_gen u_gen (
        .clk     (clk),
        .rst     (rst),
        .load    (gen_load),
        .adv     (gen_adv),
        .mode    (mode),
        .seed    (seed),
        .state_o (gen_state)
    );

    assign ref_bit = (pc_q >= THRESH_V);

    always_comb begin
        state_d      = state_q;
        num_vec_d    = num_vec_q;
        x_d          = x_q;
        sh_d         = sh_q;
        pc_d         = pc_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        fail_valid_d = fail_valid_q;
        fail_vec_d   = fail_vec_q;
        fail_idx_d   = fail_idx_q;
        vec_idx_d    = vec_idx_q;
        pass_d       = pass_q;
        done_d       = 1'b0;
        gen_load     = 1'b0;
        gen_adv      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    gen_load     = 1'b1;
                    num_vec_d    = num_vec;
                    err_d        = '0;
                    fail_valid_d = 1'b0;
                    fail_vec_d   = '0;
                    fail_idx_d   = '0;
                    vec_idx_d    = '0;
                    pass_d       = 1'b0;
                    state_d      = (num_vec == '0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                x_d     = gen_state[N-1:0];
                sh_d    = gen_state[N-1:0];
                pc_d    = '0;
                cnt_d   = N_V;
                state_d = ST_COUNT;
            end
            ST_COUNT: begin
                pc_d  = pc_q + PC_W'(sh_q[0]);
                sh_d  = sh_q >> 1;
                cnt_d = cnt_q - PC_W'(1);
                if (cnt_q == PC_W'(1)) begin
                    state_d = ST_COMPARE;
                end
            end
            ST_COMPARE: begin
                if (ref_bit != y0_i) begin
                    if (err_q != '1) begin
                        err_d = err_q + ERR_W'(1);
                    end
                    if (!fail_valid_q) begin
                        fail_valid_d = 1'b1;
                        fail_vec_d   = x_q;
                        fail_idx_d   = vec_idx_q;
                    end
                end
                vec_idx_d = vec_idx_q + CNT_W'(1);
                if (vec_idx_d == num_vec_q) begin
                    state_d = ST_DONE;
                end else begin
                    gen_adv = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                pass_d  = (err_q == '0);
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            num_vec_q    <= '0;
            x_q          <= '0;
            sh_q         <= '0;
            pc_q         <= '0;
            cnt_q        <= '0;
            err_q        <= '0;
            fail_valid_q <= 1'b0;
            fail_vec_q   <= '0;
            fail_idx_q   <= '0;
            vec_idx_q    <= '0;
            pass_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            num_vec_q    <= num_vec_d;
            x_q          <= x_d;
            sh_q         <= sh_d;
            pc_q         <= pc_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            fail_valid_q <= fail_valid_d;
            fail_vec_q   <= fail_vec_d;
            fail_idx_q   <= fail_idx_d;
            vec_idx_q    <= vec_idx_d;
            pass_q       <= pass_d;
            done_q       <= done_d;
        end
    end

    assign x_o        = x_q;
    assign busy       = (state_q != ST_IDLE);
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_cnt    = err_q;
    assign fail_valid = fail_valid_q;
    assign fail_vec   = fail_vec_q;
    assign fail_idx   = fail_idx_q;
    assign vec_idx    = vec_idx_q;

endmodule

// File: tb/tb_maj_bist_checker.sv
// Self-checking bench for maj_bist_checker: a behavioural majority DUT with
// selectable faults, table-driven runs, reset/start corner cases and random runs.
module tb_maj_bist_checker;

    localparam int N      = 51;
    localparam int CNT_W  = 32;
    localparam int ERR_W  = 4;
    localparam int PER    = N + 2;
    localparam int ERRMAX = (1 << ERR_W) - 1;

    logic             clk, rst, start, mode, y0_i;
    logic [63:0]      seed;
    logic [CNT_W-1:0] num_vec;
    logic [N-1:0]     x_o, fail_vec;
    logic             busy, done, pass, fail_valid;
    logic [ERR_W-1:0] err_cnt;
    logic [CNT_W-1:0] fail_idx, vec_idx;

    int fault_sel;   // 0 ideal, 1 stuck-at-0, 2 stuck-at-1, 3 inverted when x[1:0]==3

    maj_bist_checker #(.N(N), .THRESH((N + 1) / 2), .CNT_W(CNT_W), .ERR_W(ERR_W)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .seed(seed),
        .num_vec(num_vec), .y0_i(y0_i), .x_o(x_o), .busy(busy), .done(done),
        .pass(pass), .err_cnt(err_cnt), .fail_valid(fail_valid),
        .fail_vec(fail_vec), .fail_idx(fail_idx), .vec_idx(vec_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit maj_ref(input logic [N-1:0] x);
        return $countones(x) >= (N + 1) / 2;
    endfunction

    function automatic bit dut_y(input int f, input logic [N-1:0] x);
        case (f)
            1: return 1'b0;
            2: return 1'b1;
            3: return maj_ref(x) ^ (x[1:0] == 2'b11);
            default: return maj_ref(x);
        endcase
    endfunction

    always_comb y0_i = dut_y(fault_sel, x_o);

    function automatic logic [63:0] gen_next(input bit m, input logic [63:0] s);
        if (!m) return s + 64'd1;
        return s[0] ? ((s >> 1) ^ 64'hD800_0000_0000_0000) : (s >> 1);
    endfunction

    int n_chk, n_fail;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference model results
    int          m_err, m_fidx;
    bit          m_fv;
    logic [N-1:0] m_fvec;
    logic [N-1:0] m_xs[64];

    task automatic model_run(input bit m, input logic [63:0] sd, input int nv, input int f);
        logic [63:0] s;
        s = (m && sd == 64'd0) ? 64'd1 : sd;
        m_err = 0; m_fv = 0; m_fidx = 0; m_fvec = '0;
        for (int v = 0; v < nv; v++) begin
            logic [N-1:0] x;
            x = s[N-1:0];
            if (v < 64) m_xs[v] = x;
            if (maj_ref(x) != dut_y(f, x)) begin
                if (m_err < ERRMAX) m_err++;
                if (!m_fv) begin m_fv = 1; m_fidx = v; m_fvec = x; end
            end
            s = gen_next(m, s);
        end
    endtask

    // Captured run results
    int           g_cyc, g_ncap;
    logic [N-1:0] g_xs[64];
    logic [N-1:0] g_xbefore;

    task automatic run_dut(input string tag, input bit m, input logic [63:0] sd,
                           input int nv, input int f, input bit glitch);
        int lim;
        fault_sel = f;
        g_xbefore = x_o;
        g_ncap = 0;
        @(posedge clk); #1;
        start = 1'b1; mode = m; seed = sd; num_vec = nv;
        @(posedge clk); #1;
        start = 1'b0;
        g_cyc = 1;
        chk({tag, " busy_after_start"}, busy, 1);
        lim = nv * PER + 10;
        while (!done && g_cyc < lim) begin
            if (glitch && (g_cyc == 20 || g_cyc == nv * PER + 1)) begin
                start = 1'b1; mode = ~mode; seed = 64'hDEAD_BEEF; num_vec = 1;
            end
            @(posedge clk); #1;
            start = 1'b0;
            g_cyc++;
            if (g_cyc >= 2 && (g_cyc - 2) % PER == 0 && g_ncap < nv && g_ncap < 64) begin
                g_xs[g_ncap] = x_o;
                g_ncap++;
            end
        end
        chk({tag, " done_seen"}, done, 1);
        chk({tag, " done_cycle"}, g_cyc, nv * PER + 2);
        chk({tag, " vec_idx"}, vec_idx, nv);
        if (nv == 0) chk({tag, " x_o_unchanged"}, x_o, g_xbefore);
        @(posedge clk); #1;
        chk({tag, " done_pulse_width"}, done, 0);
        chk({tag, " busy_after_done"}, busy, 0);
    endtask

    task automatic check_seq(input string tag, input int nv);
        int lim;
        lim = (nv < 64) ? nv : 64;
        chk({tag, " n_vectors_seen"}, g_ncap, lim);
        for (int i = 0; i < lim && i < g_ncap; i++)
            chk($sformatf("%s x_o[%0d]", tag, i), g_xs[i], m_xs[i]);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " x_o"}, x_o, 0);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " done"}, done, 0);
        chk({tag, " pass"}, pass, 0);
        chk({tag, " err_cnt"}, err_cnt, 0);
        chk({tag, " fail_valid"}, fail_valid, 0);
        chk({tag, " fail_vec"}, fail_vec, 0);
        chk({tag, " fail_idx"}, fail_idx, 0);
        chk({tag, " vec_idx"}, vec_idx, 0);
    endtask

    typedef struct {
        bit          m;
        logic [63:0] sd;
        int          nv;
        int          f;
        bit          glitch;
        int          e_err;
        bit          e_pass;
        bit          e_fv;
        int          e_fidx;
        logic [63:0] e_fvec;
    } vec_t;

    vec_t tbl[10];

    initial begin
        n_chk = 0; n_fail = 0;
        rst = 1'b1; start = 1'b0; mode = 1'b0; seed = '0; num_vec = '0; fault_sel = 0;
        tbl[0] = '{0, 64'h0,        0,  0, 0, 0,  1, 0, 0, 64'h0};
        tbl[1] = '{0, 64'h0,        4,  0, 0, 0,  1, 0, 0, 64'h0};
        tbl[2] = '{0, 64'h3FFFFFF,  1,  0, 0, 0,  1, 0, 0, 64'h0};
        tbl[3] = '{0, 64'h1FFFFFF,  1,  0, 0, 0,  1, 0, 0, 64'h0};
        tbl[4] = '{0, 64'h3FFFFFF,  1,  1, 0, 1,  0, 1, 0, 64'h3FFFFFF};
        tbl[5] = '{0, 64'h1FFFFFF,  1,  2, 0, 1,  0, 1, 0, 64'h1FFFFFF};
        tbl[6] = '{0, 64'h3FFFFFE,  3,  1, 0, 1,  0, 1, 1, 64'h3FFFFFF};
        tbl[7] = '{1, 64'h0,        2,  0, 0, 0,  1, 0, 0, 64'h0};
        tbl[8] = '{0, 64'h0,        20, 2, 0, 15, 0, 1, 0, 64'h0};
        tbl[9] = '{0, 64'h7,        2,  0, 1, 0,  1, 0, 0, 64'h0};

        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            string tag;
            tag = $sformatf("tbl%0d", i);
            model_run(tbl[i].m, tbl[i].sd, tbl[i].nv, tbl[i].f);
            run_dut(tag, tbl[i].m, tbl[i].sd, tbl[i].nv, tbl[i].f, tbl[i].glitch);
            check_seq(tag, tbl[i].nv);
            chk({tag, " err_cnt"}, err_cnt, tbl[i].e_err);
            chk({tag, " pass"}, pass, tbl[i].e_pass);
            chk({tag, " fail_valid"}, fail_valid, tbl[i].e_fv);
            chk({tag, " fail_idx"}, fail_idx, tbl[i].e_fidx);
            chk({tag, " fail_vec"}, fail_vec, tbl[i].e_fvec);
        end

        // Hand-computed sequences: counter from 0, and LFSR from zero seed.
        begin
            model_run(0, 64'h0, 4, 0);
            chk("seq_cnt x3", m_xs[3], 3);
            model_run(1, 64'h0, 2, 0);
            chk("seq_lfsr x0", m_xs[0], 1);
            chk("seq_lfsr x1", m_xs[1], 0);
        end

        // Reset during COUNT of vector 2 with errors already recorded.
        begin
            int dones;
            fault_sel = 2;
            @(posedge clk); #1;
            start = 1'b1; mode = 1'b0; seed = 64'h5; num_vec = 4;
            @(posedge clk); #1;
            start = 1'b0;
            repeat (1 + 2 * PER + 10) @(posedge clk);
            #1;
            chk("midrun err_before_reset", err_cnt, 2);
            chk("midrun busy_before_reset", busy, 1);
            rst = 1'b1;
            #1;
            chk_all_zero("midrun_reset");
            @(posedge clk); #1;
            rst = 1'b0;
            dones = 0;
            for (int c = 0; c < 3 * PER; c++) begin
                @(posedge clk); #1;
                if (done) dones++;
            end
            chk("midrun no_done", dones, 0);
            chk("midrun stays_idle", busy, 0);
        end

        // Clean run after the abort.
        model_run(0, 64'h3FFFFFE, 3, 1);
        run_dut("post_reset", 0, 64'h3FFFFFE, 3, 1, 0);
        check_seq("post_reset", 3);
        chk("post_reset err_cnt", err_cnt, 1);
        chk("post_reset fail_idx", fail_idx, 1);
        chk("post_reset fail_vec", fail_vec, 64'h3FFFFFF);
        chk("post_reset pass", pass, 0);

        // Randomised runs against the model.
        for (int r = 0; r < 12; r++) begin
            bit          m;
            logic [63:0] sd;
            int          nv, f;
            string       tag;
            tag = $sformatf("rnd%0d", r);
            m  = 1'($urandom_range(0, 1));
            sd = ($urandom_range(0, 3) == 0) ? 64'h0 : {$urandom, $urandom};
            nv = $urandom_range(1, 5);
            f  = $urandom_range(0, 3);
            model_run(m, sd, nv, f);
            run_dut(tag, m, sd, nv, f, 0);
            check_seq(tag, nv);
            chk({tag, " err_cnt"}, err_cnt, m_err);
            chk({tag, " pass"}, pass, (m_err == 0));
            chk({tag, " fail_valid"}, fail_valid, m_fv);
            chk({tag, " fail_idx"}, fail_idx, m_fidx);
            chk({tag, " fail_vec"}, fail_vec, m_fvec);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
